pwm_duty_monitor: RTL and testbench



---
 rtl/pwm_duty_monitor_pkg.sv | 24 ++
 rtl/pwm_chan_meas.sv | 176 +++++++++++++++++
 rtl/pwm_duty_monitor.sv | 40 ++++
 tb/tb_pwm_duty_monitor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_duty_monitor_pkg.sv
// Shared definitions for the PWM duty monitor: channel FSM encoding and
// helpers for the all-ones saturation / full-scale constants.
package pwm_duty_monitor_pkg;

    typedef enum logic [1:0] {
        WAIT_EDGE = 2'd0,
        MEASURE   = 2'd1,
        STUCK     = 2'd2
    } chan_state_e;

    // All-ones value of a w-bit field, usable in constant expressions.
    function automatic int unsigned all_ones(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic int unsigned sat_value(input int unsigned cnt_w);
        return all_ones(cnt_w);
    endfunction

    function automatic int unsigned full_scale(input int unsigned duty_w);
        return all_ones(duty_w);
    endfunction

endpackage

// File: rtl/pwm_chan_meas.sv
// One PWM measurement channel: input synchronizer, period/high counters,
// duty averaging over 2^AVG_LOG2 periods and stuck-level detection.
module pwm_chan_meas
    import pwm_duty_monitor_pkg::*;
#(
    parameter int unsigned CNT_W    = 12,
    parameter int unsigned DUTY_W   = 8,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              pwm,
    output logic [DUTY_W-1:0] duty,
    output logic [CNT_W-1:0]  period,
    output logic              vld,
    output logic              stuck_hi,
    output logic              stuck_lo
);

    localparam int unsigned ACC_W = CNT_W + AVG_LOG2;
    localparam int unsigned N_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned CMP_W = (ACC_W > DUTY_W) ? ACC_W : DUTY_W;

    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(sat_value(CNT_W));
    localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(full_scale(DUTY_W));
    localparam logic [N_W-1:0]    N_LAST   = N_W'(all_ones(AVG_LOG2));

    logic s1, s2, s3;
    logic rise;

    chan_state_e       state, state_d;
    logic [CNT_W-1:0]  per_cnt, per_cnt_d;
    logic [CNT_W-1:0]  hi_cnt, hi_cnt_d;
    logic [ACC_W-1:0]  acc, acc_d;
    logic [N_W-1:0]    n, n_d;
    logic [DUTY_W-1:0] duty_d;
    logic [CNT_W-1:0]  period_d;
    logic              vld_d, stuck_hi_d, stuck_lo_d;

    logic [ACC_W-1:0]  sum;
    logic [CMP_W-1:0]  avg;
    logic [DUTY_W-1:0] duty_avg;

    // Synchronizer and edge-delay flops; only the hard reset clears them so
    // that clr while the input is high cannot fake a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise     = s2 & ~s3;
    assign sum      = acc + ACC_W'(hi_cnt);
    assign avg      = CMP_W'(sum >> AVG_LOG2);
    assign duty_avg = (avg > CMP_W'(DUTY_MAX)) ? DUTY_MAX : DUTY_W'(avg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WAIT_EDGE;
            per_cnt  <= '0;
            hi_cnt   <= '0;
            acc      <= '0;
            n        <= '0;
            duty     <= '0;
            period   <= '0;
            vld      <= 1'b0;
            stuck_hi <= 1'b0;
            stuck_lo <= 1'b0;
        end else begin
            state    <= state_d;
            per_cnt  <= per_cnt_d;
            hi_cnt   <= hi_cnt_d;
            acc      <= acc_d;
            n        <= n_d;
            duty     <= duty_d;
            period   <= period_d;
            vld      <= vld_d;
            stuck_hi <= stuck_hi_d;
            stuck_lo <= stuck_lo_d;
        end
    end

    // Next-state and datapath update; a rise always wins over saturation.
    always_comb begin
        state_d    = state;
        per_cnt_d  = per_cnt;
        hi_cnt_d   = hi_cnt;
        acc_d      = acc;
        n_d        = n;
        duty_d     = duty;
        period_d   = period;
        vld_d      = vld;
        stuck_hi_d = stuck_hi;
        stuck_lo_d = stuck_lo;

        if (clr) begin
            state_d    = WAIT_EDGE;
            per_cnt_d  = '0;
            hi_cnt_d   = '0;
            acc_d      = '0;
            n_d        = '0;
            duty_d     = '0;
            period_d   = '0;
            vld_d      = 1'b0;
            stuck_hi_d = 1'b0;
            stuck_lo_d = 1'b0;
        end else begin
            case (state)
                WAIT_EDGE: begin
                    if (rise) begin
                        state_d   = MEASURE;
                        per_cnt_d = CNT_W'(1);
                        hi_cnt_d  = CNT_W'(1);
                        acc_d     = '0;
                        n_d       = '0;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d  = per_cnt;
                        per_cnt_d = CNT_W'(1);
                        hi_cnt_d  = CNT_W'(1);
                        if (n == N_LAST) begin
                            n_d    = '0;
                            acc_d  = '0;
                            duty_d = duty_avg;
                            vld_d  = 1'b1;
                        end else begin
                            n_d   = n + N_W'(1);
                            acc_d = sum;
                        end
                    end else if (per_cnt == CNT_SAT) begin
                        state_d    = STUCK;
                        period_d   = CNT_SAT;
                        duty_d     = s2 ? DUTY_MAX : '0;
                        vld_d      = 1'b1;
                        stuck_hi_d = s2;
                        stuck_lo_d = ~s2;
                    end else begin
                        per_cnt_d = per_cnt + CNT_W'(1);
                        if (s2 && (hi_cnt != CNT_SAT)) begin
                            hi_cnt_d = hi_cnt + CNT_W'(1);
                        end
                    end
                end
                STUCK: begin
                    if (rise) begin
                        state_d    = MEASURE;
                        per_cnt_d  = CNT_W'(1);
                        hi_cnt_d   = CNT_W'(1);
                        acc_d      = '0;
                        n_d        = '0;
                        vld_d      = 1'b0;
                        stuck_hi_d = 1'b0;
                        stuck_lo_d = 1'b0;
                    end else begin
                        period_d   = CNT_SAT;
                        duty_d     = s2 ? DUTY_MAX : '0;
                        vld_d      = 1'b1;
                        stuck_hi_d = s2;
                        stuck_lo_d = ~s2;
                    end
                end
                default: state_d = WAIT_EDGE;
            endcase
        end
    end

endmodule

// File: rtl/pwm_duty_monitor.sv
// Multi-channel PWM period/duty monitor: NCH independent channel meters
// packed onto flat output buses.
module pwm_duty_monitor
    import pwm_duty_monitor_pkg::*;
#(
    parameter int unsigned NCH      = 4,
    parameter int unsigned CNT_W    = 12,
    parameter int unsigned DUTY_W   = 8,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic [NCH-1:0]          pwm,
    output logic [NCH*DUTY_W-1:0]   duty,
    output logic [NCH*CNT_W-1:0]    period,
    output logic [NCH-1:0]          vld,
    output logic [NCH-1:0]          stuck_hi,
    output logic [NCH-1:0]          stuck_lo
);

    for (genvar i = 0; i < int'(NCH); i++) begin : g_chan
        pwm_chan_meas #(
            .CNT_W    (CNT_W),
            .DUTY_W   (DUTY_W),
            .AVG_LOG2 (AVG_LOG2)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (clr),
            .pwm      (pwm[i]),
            .duty     (duty[i*DUTY_W +: DUTY_W]),
            .period   (period[i*CNT_W +: CNT_W]),
            .vld      (vld[i]),
            .stuck_hi (stuck_hi[i]),
            .stuck_lo (stuck_lo[i])
        );
    end

endmodule

// File: tb/tb_pwm_duty_monitor.sv
// Directed bench for pwm_duty_monitor: steady duty, averaging, saturation,
// stuck detection, clr and asynchronous reset.
module tb_pwm_duty_monitor;

    localparam int unsigned NCH      = 4;
    localparam int unsigned CNT_W    = 12;
    localparam int unsigned DUTY_W   = 8;
    localparam int unsigned AVG_LOG2 = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  clr;
    logic [NCH-1:0]        pwm;
    logic [NCH*DUTY_W-1:0] duty;
    logic [NCH*CNT_W-1:0]  period;
    logic [NCH-1:0]        vld;
    logic [NCH-1:0]        stuck_hi;
    logic [NCH-1:0]        stuck_lo;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    pwm_duty_monitor #(
        .NCH(NCH), .CNT_W(CNT_W), .DUTY_W(DUTY_W), .AVG_LOG2(AVG_LOG2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .pwm(pwm), .duty(duty),
        .period(period), .vld(vld), .stuck_hi(stuck_hi), .stuck_lo(stuck_lo)
    );

    function automatic logic [DUTY_W-1:0] duty_of(input int ch);
        return duty[ch*DUTY_W +: DUTY_W];
    endfunction

    function automatic logic [CNT_W-1:0] period_of(input int ch);
        return period[ch*CNT_W +: CNT_W];
    endfunction

    // One level per clock, changed just after the rising edge.
    task automatic drive_level(input int ch, input logic lvl, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            pwm[ch] = lvl;
        end
    endtask

    task automatic drive_pwm(input int ch, input int per, input int hi, input int nper);
        for (int p = 0; p < nper; p++) begin
            drive_level(ch, 1'b1, hi);
            drive_level(ch, 1'b0, per - hi);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; pwm = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (duty !== '0) begin fails++; $display("FAIL reset_duty: got %h want 0", duty); end
        checks++; if (period !== '0) begin fails++; $display("FAIL reset_period: got %h want 0", period); end
        checks++; if (vld !== '0) begin fails++; $display("FAIL reset_vld: got %b want 0000", vld); end
        checks++; if (stuck_hi !== '0) begin fails++; $display("FAIL reset_stuck_hi: got %b want 0000", stuck_hi); end
        checks++; if (stuck_lo !== '0) begin fails++; $display("FAIL reset_stuck_lo: got %b want 0000", stuck_lo); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_steady();
        drive_pwm(0, 256, 64, 4);
        drive_level(0, 1'b1, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (vld[0] !== 1'b0) begin fails++; $display("FAIL steady_latency_early: vld got %b want 0", vld[0]); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (vld[0] !== 1'b1) begin fails++; $display("FAIL steady_vld: got %b want 1", vld[0]); end
        checks++; if (duty_of(0) !== 8'h40) begin fails++; $display("FAIL steady_duty: got %h want 40", duty_of(0)); end
        checks++; if (period_of(0) !== 12'h100) begin fails++; $display("FAIL steady_period: got %h want 100", period_of(0)); end
        checks++; if (vld[3:1] !== 3'b000) begin fails++; $display("FAIL steady_other_vld: got %b want 000", vld[3:1]); end
        drive_level(0, 1'b1, 60);
        drive_level(0, 1'b0, 192);
    endtask

    task automatic test_stuck_lo();
        drive_level(0, 1'b0, 3800);
        @(negedge clk);
        checks++; if (stuck_lo[0] !== 1'b0) begin fails++; $display("FAIL stuck_lo_early: got %b want 0", stuck_lo[0]); end
        checks++; if (duty_of(0) !== 8'h40) begin fails++; $display("FAIL stuck_lo_hold_duty: got %h want 40", duty_of(0)); end
        drive_level(0, 1'b0, 50);
        @(negedge clk);
        checks++; if (stuck_lo[0] !== 1'b1) begin fails++; $display("FAIL stuck_lo_flag: got %b want 1", stuck_lo[0]); end
        checks++; if (stuck_hi[0] !== 1'b0) begin fails++; $display("FAIL stuck_lo_hi_flag: got %b want 0", stuck_hi[0]); end
        checks++; if (duty_of(0) !== 8'h00) begin fails++; $display("FAIL stuck_lo_duty: got %h want 00", duty_of(0)); end
        checks++; if (period_of(0) !== 12'hFFF) begin fails++; $display("FAIL stuck_lo_period: got %h want fff", period_of(0)); end
        checks++; if (vld[0] !== 1'b1) begin fails++; $display("FAIL stuck_lo_vld: got %b want 1", vld[0]); end
    endtask

    task automatic test_average();
        drive_pwm(1, 256, 8'h20, 1);
        drive_pwm(1, 256, 8'h40, 1);
        drive_pwm(1, 256, 8'h60, 1);
        drive_pwm(1, 256, 8'h80, 1);
        drive_pwm(1, 256, 8'h10, 1);
        @(negedge clk);
        checks++; if (duty_of(1) !== 8'h50) begin fails++; $display("FAIL average_duty: got %h want 50", duty_of(1)); end
        checks++; if (period_of(1) !== 12'h100) begin fails++; $display("FAIL average_period: got %h want 100", period_of(1)); end
        checks++; if (vld[1] !== 1'b1) begin fails++; $display("FAIL average_vld: got %b want 1", vld[1]); end
        drive_pwm(1, 256, 8'h10, 3);
        @(negedge clk);
        checks++; if (duty_of(1) !== 8'h50) begin fails++; $display("FAIL average_hold: got %h want 50", duty_of(1)); end
        drive_level(1, 1'b1, 4);
        @(negedge clk);
        checks++; if (duty_of(1) !== 8'h10) begin fails++; $display("FAIL average_next_group: got %h want 10", duty_of(1)); end
    endtask

    task automatic test_saturate();
        drive_pwm(2, 300, 280, 5);
        @(negedge clk);
        checks++; if (duty_of(2) !== 8'hFF) begin fails++; $display("FAIL saturate_duty: got %h want ff", duty_of(2)); end
        checks++; if (period_of(2) !== 12'h12C) begin fails++; $display("FAIL saturate_period: got %h want 12c", period_of(2)); end
        checks++; if (vld[2] !== 1'b1) begin fails++; $display("FAIL saturate_vld: got %b want 1", vld[2]); end
        checks++; if (stuck_hi[2] !== 1'b0) begin fails++; $display("FAIL saturate_not_stuck: got %b want 0", stuck_hi[2]); end
    endtask

    task automatic test_stuck_hi();
        drive_level(3, 1'b1, 4090);
        @(negedge clk);
        checks++; if (stuck_hi[3] !== 1'b0) begin fails++; $display("FAIL stuck_hi_early: got %b want 0", stuck_hi[3]); end
        drive_level(3, 1'b1, 10);
        @(negedge clk);
        checks++; if (stuck_hi[3] !== 1'b1) begin fails++; $display("FAIL stuck_hi_flag: got %b want 1", stuck_hi[3]); end
        checks++; if (stuck_lo[3] !== 1'b0) begin fails++; $display("FAIL stuck_hi_lo_flag: got %b want 0", stuck_lo[3]); end
        checks++; if (duty_of(3) !== 8'hFF) begin fails++; $display("FAIL stuck_hi_duty: got %h want ff", duty_of(3)); end
        checks++; if (period_of(3) !== 12'hFFF) begin fails++; $display("FAIL stuck_hi_period: got %h want fff", period_of(3)); end
        checks++; if (vld[3] !== 1'b1) begin fails++; $display("FAIL stuck_hi_vld: got %b want 1", vld[3]); end
        drive_level(3, 1'b0, 128);
        @(negedge clk);
        checks++; if (stuck_lo[3] !== 1'b1) begin fails++; $display("FAIL stuck_track_lo: got %b want 1", stuck_lo[3]); end
        checks++; if (duty_of(3) !== 8'h00) begin fails++; $display("FAIL stuck_track_duty: got %h want 00", duty_of(3)); end
        drive_level(3, 1'b1, 4);
        @(negedge clk);
        checks++; if ({stuck_hi[3], stuck_lo[3]} !== 2'b00) begin fails++; $display("FAIL stuck_release_flags: got %b want 00", {stuck_hi[3], stuck_lo[3]}); end
        checks++; if (vld[3] !== 1'b0) begin fails++; $display("FAIL stuck_release_vld: got %b want 0", vld[3]); end
        drive_level(3, 1'b1, 124);
        drive_level(3, 1'b0, 128);
        drive_pwm(3, 256, 128, 3);
        @(negedge clk);
        checks++; if (vld[3] !== 1'b0) begin fails++; $display("FAIL resume_vld_early: got %b want 0", vld[3]); end
        drive_level(3, 1'b1, 4);
        @(negedge clk);
        checks++; if (vld[3] !== 1'b1) begin fails++; $display("FAIL resume_vld: got %b want 1", vld[3]); end
        checks++; if (duty_of(3) !== 8'h80) begin fails++; $display("FAIL resume_duty: got %h want 80", duty_of(3)); end
        checks++; if (period_of(3) !== 12'h100) begin fails++; $display("FAIL resume_period: got %h want 100", period_of(3)); end
    endtask

    task automatic test_clr();
        drive_level(2, 1'b1, 20);
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        checks++; if (duty !== '0) begin fails++; $display("FAIL clr_duty: got %h want 0", duty); end
        checks++; if (period !== '0) begin fails++; $display("FAIL clr_period: got %h want 0", period); end
        checks++; if (vld !== '0) begin fails++; $display("FAIL clr_vld: got %b want 0000", vld); end
        checks++; if ({stuck_hi, stuck_lo} !== '0) begin fails++; $display("FAIL clr_stuck: got %b want 0", {stuck_hi, stuck_lo}); end
        drive_level(2, 1'b1, 30);
        drive_level(2, 1'b0, 206);
        drive_pwm(2, 256, 64, 4);
        @(negedge clk);
        checks++; if (vld[2] !== 1'b0) begin fails++; $display("FAIL clr_partial_discard: vld got %b want 0", vld[2]); end
        drive_level(2, 1'b1, 4);
        @(negedge clk);
        checks++; if (vld[2] !== 1'b1) begin fails++; $display("FAIL clr_restart_vld: got %b want 1", vld[2]); end
        checks++; if (duty_of(2) !== 8'h40) begin fails++; $display("FAIL clr_restart_duty: got %h want 40", duty_of(2)); end
        checks++; if (period_of(2) !== 12'h100) begin fails++; $display("FAIL clr_restart_period: got %h want 100", period_of(2)); end
    endtask

    task automatic test_async_reset();
        drive_level(2, 1'b1, 20);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++; if (vld !== '0) begin fails++; $display("FAIL async_rst_vld: got %b want 0000", vld); end
        checks++; if (duty !== '0) begin fails++; $display("FAIL async_rst_duty: got %h want 0", duty); end
        checks++; if (period !== '0) begin fails++; $display("FAIL async_rst_period: got %h want 0", period); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_steady();
        test_stuck_lo();
        test_average();
        test_saturate();
        test_stuck_hi();
        test_clr();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
